// File: rtl/cap_seq_pkg.sv
// Shared types, default constants and width helpers for the capture sequencer.
// CAP_TRIG_EN adds the trigger-level default used by the optional rising-crossing wait.
package cap_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    DETECT = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned DEF_DATA_W  = 10;
  localparam int unsigned DEF_FREQ_W  = 20;
  localparam int unsigned DEF_CAP_LEN = 1024;
  localparam int unsigned DEF_TIMEOUT = 50_000_000;
`ifdef CAP_TRIG_EN
  localparam int unsigned DEF_TRIG_LEVEL = 512;
`endif

  // Sample counter width: must represent CAP_LEN itself.
  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Timeout counter width: must represent TIMEOUT-1, never narrower than 1 bit.
  function automatic int unsigned tmo_w(input int unsigned tmo);
    return (tmo < 2) ? 1 : $clog2(tmo);
  endfunction

endpackage

// File: rtl/cap_decimator.sv
// Keep-1-of-N sample decimator; keep_c is combinational for the sample presented this cycle.
module cap_decimator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       phase_clr,
  input  logic       ad_valid,
  input  logic [7:0] ratio,
  output logic       keep_c
);

  logic [7:0] phase_q;

  assign keep_c = en && ad_valid && (phase_q == 8'd0);

  // Phase advances on every accepted sample and wraps at ratio-1 (ratio is never 0 here).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 8'd0;
    end else if (phase_clr) begin
      phase_q <= 8'd0;
    end else if (en && ad_valid) begin
      phase_q <= (phase_q >= (ratio - 8'd1)) ? 8'd0 : (phase_q + 8'd1);
    end
  end

endmodule

// File: rtl/cap_seq_ctrl.sv
// Acquisition sequencer: start -> FFT frequency measurement (with timeout) -> decimated capture
// of CAP_LEN samples into the FIFO. Define CAP_TRIG_EN to make STORE wait for a rising crossing
// of TRIG_LEVEL before the first write.
module cap_seq_ctrl
  import cap_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FREQ_W  = DEF_FREQ_W,
  parameter int unsigned CAP_LEN = DEF_CAP_LEN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
`ifdef CAP_TRIG_EN
  ,
  parameter int unsigned TRIG_LEVEL = DEF_TRIG_LEVEL
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        dec_ratio,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  output logic              fft_start,
  input  logic              freq_valid,
  input  logic [FREQ_W-1:0] wave_freq,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic [FREQ_W-1:0] freq_out,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              overrun
);

  localparam int unsigned CNT_W = cnt_w(CAP_LEN);
  localparam int unsigned TMO_W = tmo_w(TIMEOUT);

  state_e              state_q, state_d;
  logic [7:0]          ratio_q, ratio_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                fft_q, fft_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_clr_c;
  logic                keep_c;
  logic                pass_c;

`ifdef CAP_TRIG_EN
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                armed_q, armed_d;
  logic                cross_c;

  // Rising crossing between the previous and current kept samples.
  assign cross_c = prev_vld_q && (prev_q < DATA_W'(TRIG_LEVEL)) && (ad_data >= DATA_W'(TRIG_LEVEL));
  assign pass_c  = armed_q || cross_c;
`else
  assign pass_c  = 1'b1;
`endif

  cap_decimator u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == STORE),
    .phase_clr (phase_clr_c),
    .ad_valid  (ad_valid),
    .ratio     (ratio_q),
    .keep_c    (keep_c)
  );

  // Next-state, counters and flags.
  always_comb begin
    state_d     = state_q;
    ratio_d     = ratio_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    freq_d      = freq_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    wr_d        = 1'b0;
    din_d       = din_q;
    phase_clr_c = 1'b0;
`ifdef CAP_TRIG_EN
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    armed_d     = armed_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = ARM;
          ratio_d = (dec_ratio == 8'd0) ? 8'd1 : dec_ratio;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ARM: begin
        tmo_d   = '0;
        state_d = abort ? IDLE : DETECT;
      end
      DETECT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (freq_valid) begin
          freq_d      = wave_freq;
          phase_clr_c = 1'b1;
          state_d     = STORE;
`ifdef CAP_TRIG_EN
          prev_vld_d  = 1'b0;
          armed_d     = 1'b0;
`endif
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      STORE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (keep_c) begin
`ifdef CAP_TRIG_EN
          prev_d     = ad_data;
          prev_vld_d = 1'b1;
          if (cross_c) armed_d = 1'b1;
`endif
          if (pass_c) begin
            if (fifo_full) begin
              ovr_d = 1'b1;
            end else begin
              wr_d  = 1'b1;
              din_d = ad_data;
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(CAP_LEN - 1)) state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    fft_d  = (state_d == ARM);
    busy_d = (state_d == ARM) || (state_d == DETECT) || (state_d == STORE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ratio_q <= 8'd1;
      tmo_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      fft_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      fft_q   <= fft_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CAP_TRIG_EN
  // Trigger history of kept samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      armed_q    <= armed_d;
    end
  end
`endif

  assign fft_start   = fft_q;
  assign fifo_wr_en  = wr_q;
  assign fifo_din    = din_q;
  assign freq_out    = freq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_cap_seq_ctrl.sv
// Scoreboard bench for cap_seq_ctrl: stimulus pushes expected FIFO writes, a monitor pops them.
module tb_cap_seq_ctrl;

  localparam int unsigned DATA_W  = 10;
  localparam int unsigned FREQ_W  = 20;
  localparam int unsigned CAP_LEN = 16;
  localparam int unsigned TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, ad_valid, freq_valid, fifo_full;
  logic [7:0]        dec_ratio;
  logic [DATA_W-1:0] ad_data;
  logic [FREQ_W-1:0] wave_freq;
  logic              fft_start, fifo_wr_en, busy, done, err_timeout, overrun;
  logic [DATA_W-1:0] fifo_din;
  logic [FREQ_W-1:0] freq_out;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int first_wr = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  cap_seq_ctrl #(
    .DATA_W  (DATA_W),
    .FREQ_W  (FREQ_W),
    .CAP_LEN (CAP_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dec_ratio   (dec_ratio),
    .ad_data     (ad_data),
    .ad_valid    (ad_valid),
    .fft_start   (fft_start),
    .freq_valid  (freq_valid),
    .wave_freq   (wave_freq),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .freq_out    (freq_out),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got write of %0d, required no write", fifo_din);
      end else begin
        chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
      end
      if (wr_cnt == 0) first_wr = int'(fifo_din);
      wr_cnt++;
    end
  end

  // Pulse start (called at a negedge) and check the ARM cycle.
  task automatic do_start(input logic [7:0] r);
    wr_cnt    = 0;
    start     = 1'b1;
    dec_ratio = r;
    @(negedge clk);
    start     = 1'b0;
    dec_ratio = 8'($urandom);
    chk("fft_start", 32'(fft_start), 32'd1);
    chk("busy_arm", 32'(busy), 32'd1);
    chk("done_clr", 32'(done), 32'd0);
    chk("err_clr", 32'(err_timeout), 32'd0);
    chk("ovr_clr", 32'(overrun), 32'd0);
  endtask

  // One capture. mode: 0 random data, 1 ramp, 2 sine. full_at/abort_at < 0 disable.
  task automatic capture(input logic [7:0] r, input logic [FREQ_W-1:0] f, input int dly,
                         input int pct, input int mode, input int full_at, input int abort_at);
    int eff, k, kept, mw, it;
    bit v, full, ab, pass, ovr_exp;
    logic [DATA_W-1:0] d;
`ifdef CAP_TRIG_EN
    bit armed, prev_vld;
    int prev;
`endif
    eff = (r == 8'd0) ? 1 : int'(r);
    do_start(r);
    for (int i = 0; i < dly; i++) begin
      ad_valid = 1'($urandom);
      ad_data  = DATA_W'($urandom);
      @(negedge clk);
      if (i == 0) chk("fft_pulse_end", 32'(fft_start), 32'd0);
    end
    freq_valid = 1'b1;
    wave_freq  = f;
    ad_valid   = 1'($urandom);
    @(negedge clk);
    freq_valid = 1'b0;
    wave_freq  = FREQ_W'($urandom);
    k = 0; kept = 0; mw = 0; it = 0; ovr_exp = 1'b0;
`ifdef CAP_TRIG_EN
    armed = 1'b0; prev_vld = 1'b0; prev = 0;
`endif
    while (mw < int'(CAP_LEN)) begin
      if (it == 5000) begin
        chk("capture_budget", 32'(mw), 32'(CAP_LEN));
        break;
      end
      v    = ($urandom_range(99) < pct);
      full = 1'($urandom);
      ab   = 1'b0;
      case (mode)
        1:       d = DATA_W'(k);
        2:       d = DATA_W'($rtoi(512.0 + 400.0 * $sin(6.2831853 * k / 37.0)));
        default: d = DATA_W'($urandom);
      endcase
      if (abort_at >= 0 && mw == abort_at) begin
        ab = 1'b1;
        v  = 1'b0;
      end
      if (v) begin
        if (k % eff == 0) begin
          full = (full_at >= 0 && kept >= full_at && kept < full_at + 3);
          pass = 1'b1;
`ifdef CAP_TRIG_EN
          if (prev_vld && prev < 512 && int'(d) >= 512) armed = 1'b1;
          pass     = armed;
          prev     = int'(d);
          prev_vld = 1'b1;
`endif
          if (pass) begin
            if (full) ovr_exp = 1'b1;
            else begin
              exp_q.push_back(int'(d));
              mw++;
            end
          end
          kept++;
        end
        k++;
      end
      start     = !ab && ($urandom_range(19) == 0);
      ad_valid  = v;
      ad_data   = d;
      fifo_full = full;
      abort     = ab;
      @(negedge clk);
      it++;
      if (ab) break;
    end
    ad_valid = 1'b0; fifo_full = 1'b0; abort = 1'b0; start = 1'b0;
    chk("done", 32'(done), (abort_at >= 0) ? 32'd0 : 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("freq_out", 32'(freq_out), 32'(f));
    chk("overrun", 32'(overrun), 32'(ovr_exp));
    chk("err_timeout_cap", 32'(err_timeout), 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(wr_cnt), 32'(mw));
    chk("done_level", 32'(done), (abort_at >= 0) ? 32'd0 : 32'd1);
    exp_q.delete();
  endtask

  // DETECT with no frequency result: error exactly 51 cycles after fft_start.
  task automatic timeout_run();
    do_start(8'd1);
    for (int j = 1; j <= 51; j++) begin
      ad_valid = 1'($urandom);
      ad_data  = DATA_W'($urandom);
      @(negedge clk);
      if (j == 50) begin
        chk("err_before_expiry", 32'(err_timeout), 32'd0);
        chk("busy_before_expiry", 32'(busy), 32'd1);
      end
      if (j == 51) begin
        chk("err_timeout", 32'(err_timeout), 32'd1);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        chk("done_after_timeout", 32'(done), 32'd0);
      end
    end
    ad_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err_timeout), 32'd1);
    chk("timeout_no_writes", 32'(wr_cnt), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ad_valid = 1'b0; freq_valid = 1'b0;
    fifo_full = 1'b0; dec_ratio = 8'd1; ad_data = '0; wave_freq = '0;
    repeat (3) @(negedge clk);
    chk("rst_fft_start", 32'(fft_start), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_freq", 32'(freq_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    capture(8'd1, 20'd1000, 40, 100, 0, -1, -1);
    capture(8'd4, FREQ_W'($urandom), 10, 100, 1, -1, -1);
    capture(8'd0, FREQ_W'($urandom), 3, 60, 1, -1, -1);
    for (int n = 0; n < 3; n++)
      capture(8'($urandom_range(6, 2)), FREQ_W'($urandom), $urandom_range(30, 1),
              $urandom_range(100, 50), 0, -1, -1);
    timeout_run();
    capture(8'd2, FREQ_W'($urandom), 50, 80, 0, -1, -1);
    capture(8'd3, FREQ_W'($urandom), 5, 90, 0, 4, -1);
    capture(8'd1, FREQ_W'($urandom), 5, 100, 0, -1, 5);
    capture(8'd1, FREQ_W'($urandom), 2, 100, 0, -1, -1);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_fft", 32'(fft_start), 32'd0);
    chk("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_abort_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of DETECT
    do_start(8'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_fft", 32'(fft_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(8'd2, FREQ_W'($urandom), 4, 100, 0, -1, -1);

`ifdef CAP_TRIG_EN
    capture(8'd1, FREQ_W'($urandom), 6, 100, 2, -1, -1);
    chk("trig_first_above", 32'(first_wr >= 512), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
